// File: rtl/ckegen_bank.sv
// ---------------------------------------------------------------------------
// ckegen_bank
//
// Multi-channel clock-enable generator. Each of N channels produces a
// one-cycle enable pulse every P[i] cycles of clk. The period of every
// channel can be changed at run time. A global gate (ena) freezes all
// counters, and a global resync (sync) restarts all counters in the same
// cycle.
//
// Optional feature, selected by the macro CKEGEN_BANK_PHASE_EN:
//   When defined, the block has a per-channel phase register and a cfg_phase
//   port. cfg_we writes the phase together with the period. On sync, a
//   counter loads its phase if the phase is less than its period, and 0
//   otherwise. When not defined, sync loads 0 into every counter.
//
// Ports
//   clk        : system clock. All state changes on its rising edge.
//   rst_       : asynchronous reset, active low.
//   ena        : global gate. While low, counters hold and no pulses are made.
//   sync       : restarts every channel counter.
//   cfg_we     : single-cycle period write strobe.
//   cfg_ch     : target channel for cfg_we.
//   cfg_period : new period for the target channel. 0 disables the channel.
//   cfg_phase  : phase offset for the target channel (phase build only).
//   cfg_err    : registered. 1-cycle pulse when cfg_we targets cfg_ch >= N.
//   cke        : registered. One enable pulse bit per channel.
// ---------------------------------------------------------------------------
module ckegen_bank #(
  parameter int          N         = 4,
  parameter int          W         = 32,
  parameter int unsigned DEFAULT_T = 50000000,
  localparam int         CH_W      = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic            ena,
  input  logic            sync,
  input  logic            cfg_we,
  input  logic [CH_W-1:0] cfg_ch,
  input  logic [W-1:0]    cfg_period,
`ifdef CKEGEN_BANK_PHASE_EN
  input  logic [W-1:0]    cfg_phase,
`endif
  output logic            cfg_err,
  output logic [N-1:0]    cke
);

  // A write is accepted only for an existing channel. The compare is done
  // at 32 bits so it stays meaningful when N is a power of two and every
  // cfg_ch code is in range.
  logic cfg_hit;
  logic cfg_bad;
  assign cfg_hit = cfg_we && (32'(cfg_ch) <  32'(N));
  assign cfg_bad = cfg_we && (32'(cfg_ch) >= 32'(N));

  logic [N-1:0] cke_d;

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [W-1:0] period_q;
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] restart;
    logic         wr;
    logic         pulse;

    assign wr = cfg_hit && (32'(cfg_ch) == 32'(i));

    // NOTE: the period registers are reset even though they form a register
    // array, because each channel must come up running at DEFAULT_T.
    always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
        period_q <= W'(DEFAULT_T);
      end else if (wr) begin
        period_q <= cfg_period;
      end
    end

`ifdef CKEGEN_BANK_PHASE_EN
    logic [W-1:0] phase_q;
    logic [W-1:0] phase_eff;
    logic [W-1:0] period_eff;

    always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
        phase_q <= '0;
      end else if (wr) begin
        phase_q <= cfg_phase;
      end
    end

    // A sync in the same cycle as a write restarts from the phase/period
    // pair being written, so the phase is clamped against its own period.
    assign phase_eff  = wr ? cfg_phase  : phase_q;
    assign period_eff = wr ? cfg_period : period_q;
    assign restart    = (phase_eff < period_eff) ? phase_eff : '0;
`else
    assign restart = '0;
`endif

    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
      cnt_d = cnt_q;
      pulse = 1'b0;
      if (sync) begin
        cnt_d = restart;
      end else if (ena) begin
        if (period_q == '0) begin
          cnt_d = '0;
        end else if (cnt_q >= period_q - W'(1)) begin
          // '>=' lets a counter beyond a freshly shrunk period wrap at once.
          cnt_d = '0;
          pulse = 1'b1;
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end
    end

    // NOTE: sequential state is written with non-blocking assignments so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign cke_d[i] = pulse;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cke     <= '0;
      cfg_err <= 1'b0;
    end else begin
      cke     <= cke_d;
      cfg_err <= cfg_bad;
    end
  end

endmodule

// File: tb/tb_ckegen_bank.sv
// ---------------------------------------------------------------------------
// tb_ckegen_bank
//
// Directed bench for ckegen_bank. The main instance has N=4, DEFAULT_T=5.
// A second instance with N=3 has a cfg_ch code (3) that addresses no
// channel, which is used to exercise cfg_err. Inputs are driven and outputs
// sampled on the falling edge. Edge numbers in tags count rising edges
// after reset release.
// ---------------------------------------------------------------------------
module tb_ckegen_bank;

  logic        clk = 1'b0;
  logic        rst_;
  logic        ena;
  logic        sync;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_period;
  logic [31:0] cfg_phase;
  logic        cfg_err;
  logic [3:0]  cke;

  logic        e_we;
  logic [1:0]  e_ch;
  logic [31:0] e_period;
  logic [31:0] e_phase;
  logic        e_err;
  logic [2:0]  e_cke;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ckegen_bank #(.N(4), .W(32), .DEFAULT_T(5)) dut (
    .clk        (clk),
    .rst_       (rst_),
    .ena        (ena),
    .sync       (sync),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
`ifdef CKEGEN_BANK_PHASE_EN
    .cfg_phase  (cfg_phase),
`endif
    .cfg_err    (cfg_err),
    .cke        (cke)
  );

  ckegen_bank #(.N(3), .W(32), .DEFAULT_T(5)) dut_err (
    .clk        (clk),
    .rst_       (rst_),
    .ena        (1'b1),
    .sync       (1'b0),
    .cfg_we     (e_we),
    .cfg_ch     (e_ch),
    .cfg_period (e_period),
`ifdef CKEGEN_BANK_PHASE_EN
    .cfg_phase  (e_phase),
`endif
    .cfg_err    (e_err),
    .cke        (e_cke)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and stop on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [3:0] exp2 [11] = '{4'hF, 4'h0, 4'h0, 4'h4, 4'h0, 4'hB, 4'h4, 4'h0, 4'h0, 4'h4, 4'hB};
  logic [3:0] exp3 [6]  = '{4'h2, 4'h2, 4'hE, 4'h2, 4'h2, 4'h6};
  logic [3:0] exp4a [6] = '{4'h2, 4'h2, 4'h6, 4'h2, 4'h2, 4'h6};
  logic [3:0] exp4b [4] = '{4'h2, 4'h2, 4'h6, 4'hA};
`ifdef CKEGEN_BANK_PHASE_EN
  logic [3:0] exp6 [8]  = '{4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h2, 4'h0, 4'h9};
`else
  logic [3:0] exp6 [8]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF};
`endif
  int unsigned ph [4]   = '{0, 2, 4, 9};

  initial begin
    rst_ = 1'b0; ena = 1'b1; sync = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_phase = '0;
    e_we = 1'b0; e_ch = '0; e_period = '0; e_phase = '0;

    repeat (2) @(negedge clk);
    check("rst_cke", 32'(cke), 32'h0);
    check("rst_err", 32'(cfg_err), 32'h0);
    rst_ = 1'b1;

    // Default period 5: all channels pulse together at edges 5 and 10.
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("dflt_e%0d", k), 32'(cke), (k % 5 == 0) ? 32'hF : 32'h0);
    end

    // Shrink P[2] to 3 so that it takes effect with cnt[2]=4.
    for (int k = 11; k <= 13; k++) begin
      step();
      check($sformatf("pre_e%0d", k), 32'(cke), 32'h0);
    end
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_period = 32'd3;
    step();
    cfg_we = 1'b0;
    check("shrink_e14", 32'(cke), 32'h0);
    for (int k = 0; k < 11; k++) begin
      step();
      check($sformatf("shrink_e%0d", k + 15), 32'(cke), 32'(exp2[k]));
    end

    // P[1]=1 then P[0]=0.
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_period = 32'd1;
    step();
    check("p1_e26", 32'(cke), 32'h0);
    cfg_ch = 2'd0; cfg_period = 32'd0;
    step();
    cfg_we = 1'b0;
    check("p0_e27", 32'(cke), 32'h6);
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("p01_e%0d", k + 28), 32'(cke), 32'(exp3[k]));
    end

    // sync together with P[3]=10, then gate ena for 7 cycles at cnt[3]=6.
    sync = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd3; cfg_period = 32'd10;
    step();
    sync = 1'b0; cfg_we = 1'b0;
    check("sync_cke_e34", 32'(cke), 32'h0);
    check("sync_err_e34", 32'(cfg_err), 32'h0);
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("run_e%0d", k + 35), 32'(cke), 32'(exp4a[k]));
    end
    ena = 1'b0;
    for (int k = 41; k <= 47; k++) begin
      step();
      check($sformatf("gate_e%0d", k), 32'(cke), 32'h0);
    end
    ena = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("resume_e%0d", k + 48), 32'(cke), 32'(exp4b[k]));
    end

    // Out-of-range write on the N=3 instance.
    e_we = 1'b1; e_ch = 2'd3; e_period = 32'd2;
    step();
    e_we = 1'b0;
    check("err_pulse_e52", 32'(e_err), 32'h1);
    step();
    check("err_clear_e53", 32'(e_err), 32'h0);
    step();
    check("err_cke_e54", 32'(e_cke), 32'h0);
    step();
    check("err_cke_e55", 32'(e_cke), 32'h7);

    // P=8 everywhere (phases 0,2,4,9 in the phase build), then sync.
    for (int c = 0; c < 4; c++) begin
      cfg_we = 1'b1; cfg_ch = 2'(c); cfg_period = 32'd8; cfg_phase = ph[c];
      step();
    end
    cfg_we = 1'b0;
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("p8_sync_e60", 32'(cke), 32'h0);
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("p8_e%0d", k + 61), 32'(cke), 32'(exp6[k]));
    end

    // Asynchronous reset while pulses are high, then restart at DEFAULT_T.
    #1 rst_ = 1'b0;
    #1;
    check("async_rst_cke", 32'(cke), 32'h0);
    check("async_rst_err", 32'(cfg_err), 32'h0);
    @(negedge clk);
    rst_ = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      check($sformatf("rerun_e%0d", k), 32'(cke), (k == 5) ? 32'hF : 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
